host_loader: RTL
================

// Module: host_loader
// PURPOSE
//  Host-side command sequencer directly upstream of the CPU core's external port (cmd/addr_in/data_in/data_out).
//  Accepts word-level host commands over valid/ready and drives the core's cmd port to load I_Cache/D_Cache
//  and read back D_Cache/RegFile contents. Also owns the core's reset, so programs are loaded while the core
//  is halted. Returns one response per command over valid/ready.
// PARAMETERS
//  RD_LAT    1   cycles from cmd/addr_in stable to data_out valid (BRAM port-b latency); legal 1..4
//  PTR_RST   0   address pointer value after reset
// PORTS
//  clk        in   1   system clock, shared with core
//  reset      in   1   asynchronous, active-low reset
//  h_valid    in   1   host command valid
//  h_ready    out  1   loader accepts command (IDLE only)
//  h_op       in   3   opcode: 0 NOP, 1 SET_ADDR, 2 WR_I, 3 WR_D, 4 RD_D, 5 RD_REG, 6 RUN, 7 HALT
//  h_data     in   32  write data / new pointer (SET_ADDR) / register index in [4:0] (RD_REG)
//  r_valid    out  1   response valid, held until r_ready
//  r_ready    in   1   host accepts response
//  r_data     out  32  read data (RD_D, RD_REG); 0 for all other ops
//  r_err      out  1   command rejected; no side effect performed
//  cpu_reset  out  1   1 = core held in reset
//  cmd        out  2   to core: 00 reg read, 01 I_Cache write, 10 D_Cache read, 11 D_Cache write
//  addr_in    out  32  to core: word pointer (caches) or {27'b0, idx} (reg read)
//  data_in    out  32  to core: write data
//  data_out   in   32  from core: read data selected by cmd
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, h_ready=1 after release, r_valid=0, r_data=0, r_err=0, cpu_reset=1,
//   cmd=00, addr_in=0, data_in=0, ptr=PTR_RST. Any in-flight command or pending response is discarded.
//  FSM: IDLE -> EXEC -> (WAIT x RD_LAT for reads) -> RESP -> IDLE.
//   IDLE: h_ready=1; h_valid&h_ready latches op/data, goes to EXEC. cmd=00 (benign) whenever not writing.
//   EXEC (1 cycle): WR_I: cmd=01, WR_D: cmd=11, addr_in=ptr, data_in=latched data, exactly one cycle;
//    ptr+=4 at end of cycle. RD_D: cmd=10, addr_in=ptr; RD_REG: cmd=00, addr_in={27'b0,idx}.
//    SET_ADDR: ptr={h_data[31:2],2'b00}. RUN: cpu_reset<=0. HALT: cpu_reset<=1. NOP: nothing.
//   WAIT: cmd/addr_in held unchanged for RD_LAT cycles; data_out captured into r_data on last WAIT cycle;
//    RD_D then ptr+=4.
//   RESP: r_valid=1, r_data/r_err stable until r_ready; r_valid&r_ready -> IDLE, cmd back to 00.
//  Latency: write = accept + 1 EXEC + RESP (r_valid 2 cycles after accept); read = 2+RD_LAT cycles.
//  Throughput: one command in flight; h_ready=0 outside IDLE (no skid buffer).
//  Rejection: WR_I/WR_D while cpu_reset=0 -> r_err=1, no cmd pulse, ptr unchanged. Reads allowed while running.
//   h_op decoding is total; no illegal opcode exists.
//  Pointer arithmetic: 32-bit, modulo 2^32; 0xFFFFFFFC+4 -> 0x00000000. ptr[1:0] always 00.
//  RUN while running / HALT while halted: no-op, r_err=0. HALT takes effect at end of EXEC cycle.
//  cmd=01/11 never asserted outside EXEC; cmd never glitches between EXEC and WAIT of the same read.
//  Simultaneous r_valid&r_ready and new h_valid: command not accepted until next cycle (IDLE).
// STRUCTURE
//  Shared package host_loader_pkg: opcode constants (OP_NOP..OP_HALT), core cmd encodings
//   (CMD_REG_RD=00, CMD_IWR=01, CMD_DRD=10, CMD_DWR=11), FSM state encodings.
//  Single module; no sub-module. All outputs registered.
// TESTING
//  Reset: hold reset=0 3 cycles, release -> cpu_reset=1, cmd=00, h_ready=1, r_valid=0.
//  Load: SET_ADDR 0x10, WR_I 0x00500093, WR_I 0x00100113 -> cmd=01 one cycle each at addr 0x10, 0x14;
//   responses r_err=0; ptr ends 0x18.
//  D readback: SET_ADDR 0x40, WR_D 0xDEADBEEF, SET_ADDR 0x40, RD_D -> r_data=0xDEADBEEF; cmd=10 held RD_LAT cycles.
//  Run guard: RUN, then WR_D 0x1234 -> r_err=1, no cmd=11 pulse; RD_REG idx 1 after program -> r_data=5;
//   HALT -> cpu_reset=1.
//  Wrap/backpressure: SET_ADDR 0xFFFFFFFF -> ptr 0xFFFFFFFC; WR_D twice -> addrs 0xFFFFFFFC then 0x0;
//   hold r_ready=0 5 cycles -> r_valid,r_data stable, h_ready=0.
//  Mid-op reset: assert reset during WAIT of RD_D -> r_valid=0, cmd=00, cpu_reset=1 immediately; no response emitted.

Source files
------------

// File: rtl/host_loader_pkg.sv
// Shared constants for the host loader: host opcodes, core cmd encodings and FSM states.
package host_loader_pkg;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_SET_ADDR = 3'd1;
  localparam logic [2:0] OP_WR_I     = 3'd2;
  localparam logic [2:0] OP_WR_D     = 3'd3;
  localparam logic [2:0] OP_RD_D     = 3'd4;
  localparam logic [2:0] OP_RD_REG   = 3'd5;
  localparam logic [2:0] OP_RUN      = 3'd6;
  localparam logic [2:0] OP_HALT     = 3'd7;

  localparam logic [1:0] CMD_REG_RD = 2'b00;
  localparam logic [1:0] CMD_IWR    = 2'b01;
  localparam logic [1:0] CMD_DRD    = 2'b10;
  localparam logic [1:0] CMD_DWR    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/host_loader.sv
// Host command sequencer in front of the core's external cmd port; loads caches, reads back
// D_Cache/RegFile and owns the core reset. One command in flight, one response per command.
module host_loader
  import host_loader_pkg::*;
#(
  parameter int unsigned RD_LAT  = 1,
  parameter logic [31:0] PTR_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [2:0]  h_op,
  input  logic [31:0] h_data,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [31:0] r_data,
  output logic        r_err,
  output logic        cpu_reset,
  output logic [1:0]  cmd,
  output logic [31:0] addr_in,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  output state_e      dbg_state
);

  // Handshakes: a command transfers on a rising edge where h_valid && h_ready;
  // a response transfers on a rising edge where r_valid && r_ready. Neither side may
  // withdraw valid before the transfer, and r_data/r_err stay stable while r_valid is high.

  localparam logic [1:0]  LAST_WAIT = 2'(RD_LAT - 1);
  localparam logic [31:0] PTR_INIT  = {PTR_RST[31:2], 2'b00};

  state_e      state, state_nxt;
  logic [2:0]  op_q, op_nxt;
  logic [31:0] data_q, data_nxt;
  logic [31:0] ptr, ptr_nxt;
  logic [1:0]  wait_cnt, cnt_nxt;
  logic        h_ready_nxt, r_valid_nxt, r_err_nxt, cpu_reset_nxt;
  logic [31:0] r_data_nxt, addr_nxt, din_nxt;
  logic [1:0]  cmd_nxt;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    op_nxt        = op_q;
    data_nxt      = data_q;
    ptr_nxt       = ptr;
    cnt_nxt       = wait_cnt;
    r_valid_nxt   = r_valid;
    r_data_nxt    = r_data;
    r_err_nxt     = r_err;
    cpu_reset_nxt = cpu_reset;
    cmd_nxt       = cmd;
    addr_nxt      = addr_in;
    din_nxt       = data_in;
    unique case (state)
      ST_IDLE: begin
        if (h_valid) begin
          state_nxt  = ST_EXEC;
          op_nxt     = h_op;
          data_nxt   = h_data;
          r_data_nxt = '0;
          r_err_nxt  = 1'b0;
          // The core port is set up on the accept edge so it is live for the whole EXEC cycle.
          unique case (h_op)
            OP_WR_I, OP_WR_D: begin
              if (cpu_reset) begin
                cmd_nxt  = (h_op == OP_WR_I) ? CMD_IWR : CMD_DWR;
                addr_nxt = ptr;
                din_nxt  = h_data;
              end else begin
                r_err_nxt = 1'b1;
              end
            end
            OP_RD_D: begin
              cmd_nxt  = CMD_DRD;
              addr_nxt = ptr;
            end
            OP_RD_REG: begin
              cmd_nxt  = CMD_REG_RD;
              addr_nxt = {27'b0, h_data[4:0]};
            end
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        state_nxt   = ST_RESP;
        r_valid_nxt = 1'b1;
        unique case (op_q)
          OP_SET_ADDR: ptr_nxt = {data_q[31:2], 2'b00};
          OP_WR_I, OP_WR_D: begin
            cmd_nxt = CMD_REG_RD;
            if (!r_err) ptr_nxt = ptr + 32'd4;
          end
          OP_RD_D, OP_RD_REG: begin
            state_nxt   = ST_WAIT;
            r_valid_nxt = 1'b0;
            cnt_nxt     = '0;
          end
          OP_RUN:  cpu_reset_nxt = 1'b0;
          OP_HALT: cpu_reset_nxt = 1'b1;
          default: ;
        endcase
      end
      ST_WAIT: begin
        if (wait_cnt == LAST_WAIT) begin
          state_nxt   = ST_RESP;
          r_valid_nxt = 1'b1;
          r_data_nxt  = data_out;
          if (op_q == OP_RD_D) ptr_nxt = ptr + 32'd4;
        end else begin
          cnt_nxt = wait_cnt + 2'd1;
        end
      end
      ST_RESP: begin
        if (r_ready) begin
          state_nxt   = ST_IDLE;
          r_valid_nxt = 1'b0;
          cmd_nxt     = CMD_REG_RD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    h_ready_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_NOP;
      data_q    <= '0;
      ptr       <= PTR_INIT;
      wait_cnt  <= '0;
      h_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_err     <= 1'b0;
      cpu_reset <= 1'b1;
      cmd       <= CMD_REG_RD;
      addr_in   <= '0;
      data_in   <= '0;
    end else begin
      op_q      <= op_nxt;
      data_q    <= data_nxt;
      ptr       <= ptr_nxt;
      wait_cnt  <= cnt_nxt;
      h_ready   <= h_ready_nxt;
      r_valid   <= r_valid_nxt;
      r_data    <= r_data_nxt;
      r_err     <= r_err_nxt;
      cpu_reset <= cpu_reset_nxt;
      cmd       <= cmd_nxt;
      addr_in   <= addr_nxt;
      data_in   <= din_nxt;
    end
  end

endmodule
